// File: rtl/ifid_hazard_ctrl.sv
// Front-end sequencer for the PC and the IF/ID register: decides each cycle whether fetch
// advances, stalls on a load-use hazard or fetch wait, or is flushed after an EX redirect.
module ifid_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned IMEM_TIMEOUT = 15,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_uses_rs1,
    input  logic             i_id_uses_rs2,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_mem_read,
    input  logic             i_redirect,
    input  logic             i_imem_ready,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_ifid_flush,
    output logic             o_idex_bubble,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_stall_count,
    output logic             o_imem_timeout
);

    localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned WC_W = $clog2(IMEM_TIMEOUT + 1);

    localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [WC_W-1:0] WAIT_MAX   = WC_W'(IMEM_TIMEOUT);

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StImemWait = 2'd1,
        StFlush    = 2'd2
    } state_e;

    state_e            r_state;
    logic [FC_W-1:0]   r_flush_cnt;
    logic [WC_W-1:0]   r_wait_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              r_timeout;

    logic              w_luh;
    logic              w_rs1_hit;
    logic              w_rs2_hit;

    // x0 is hard-wired, so a load targeting it can never create a real dependency.
    assign w_rs1_hit = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
    assign w_luh     = i_ex_mem_read && (i_ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);

    always_comb begin
        o_pc_en       = 1'b0;
        o_ifid_en     = 1'b1;
        o_ifid_flush  = 1'b1;
        o_idex_bubble = 1'b1;
        if (!i_rst_n) begin
            o_pc_en = 1'b0;
        end else if (i_redirect) begin
            o_pc_en = 1'b1;
        end else if (w_luh) begin
            o_ifid_en    = 1'b0;
            o_ifid_flush = 1'b0;
        end else begin
            o_pc_en       = i_imem_ready;
            o_idex_bubble = 1'b0;
            // During FLUSH the fetched word is always discarded, ready or not.
            o_ifid_flush  = (r_state == StFlush) ? 1'b1 : !i_imem_ready;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StRun;
            r_flush_cnt <= '0;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (!o_pc_en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end

            if (i_redirect) begin
                r_flush_cnt <= FLUSH_LOAD;
                r_state     <= (FLUSH_CYCLES > 1) ? StFlush : StRun;
            end else if (!w_luh) begin
                unique case (r_state)
                    StRun: begin
                        if (!i_imem_ready) begin
                            r_state    <= StImemWait;
                            r_wait_cnt <= WC_W'(1);
                            if (WAIT_MAX == WC_W'(1)) begin
                                r_timeout <= 1'b1;
                            end
                        end
                    end
                    StImemWait: begin
                        if (i_imem_ready) begin
                            r_state <= StRun;
                        end else if (r_wait_cnt < WAIT_MAX) begin
                            r_wait_cnt <= r_wait_cnt + WC_W'(1);
                            if ((r_wait_cnt + WC_W'(1)) == WAIT_MAX) begin
                                r_timeout <= 1'b1;
                            end
                        end
                    end
                    StFlush: begin
                        if (i_imem_ready) begin
                            r_flush_cnt <= r_flush_cnt - FC_W'(1);
                            if (r_flush_cnt <= FC_W'(1)) begin
                                r_state <= StRun;
                            end
                        end
                    end
                    default: r_state <= StRun;
                endcase
            end
        end
    end

    assign o_state        = r_state;
    assign o_stall_count  = r_stall_cnt;
    assign o_imem_timeout = r_timeout;

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Directed and randomized bench for ifid_hazard_ctrl against a cycle-level reference model.
module tb_ifid_hazard_ctrl;

    localparam int unsigned FLUSH_CYCLES = 2;
    localparam int unsigned IMEM_TIMEOUT = 15;
    localparam int unsigned CNT_W        = 16;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic [4:0]       i_id_rs1;
    logic [4:0]       i_id_rs2;
    logic             i_id_uses_rs1;
    logic             i_id_uses_rs2;
    logic [4:0]       i_ex_rd;
    logic             i_ex_mem_read;
    logic             i_redirect;
    logic             i_imem_ready;
    logic             o_pc_en;
    logic             o_ifid_en;
    logic             o_ifid_flush;
    logic             o_idex_bubble;
    logic [1:0]       o_state;
    logic [CNT_W-1:0] o_stall_count;
    logic             o_imem_timeout;

    always #5 i_clk = ~i_clk;

    ifid_hazard_ctrl #(
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .IMEM_TIMEOUT (IMEM_TIMEOUT),
        .CNT_W        (CNT_W)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_id_rs1       (i_id_rs1),
        .i_id_rs2       (i_id_rs2),
        .i_id_uses_rs1  (i_id_uses_rs1),
        .i_id_uses_rs2  (i_id_uses_rs2),
        .i_ex_rd        (i_ex_rd),
        .i_ex_mem_read  (i_ex_mem_read),
        .i_redirect     (i_redirect),
        .i_imem_ready   (i_imem_ready),
        .o_pc_en        (o_pc_en),
        .o_ifid_en      (o_ifid_en),
        .o_ifid_flush   (o_ifid_flush),
        .o_idex_bubble  (o_idex_bubble),
        .o_state        (o_state),
        .o_stall_count  (o_stall_count),
        .o_imem_timeout (o_imem_timeout)
    );

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // Reference model: 0 RUN, 1 fetch wait, 2 flushing; counters as plain integers.
    int m_mode;
    int m_flush_left;
    int m_wait;
    int m_stall;
    bit m_timeout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode       = 0;
        m_flush_left = 0;
        m_wait       = 0;
        m_stall      = 0;
        m_timeout    = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pc_en"},   32'(o_pc_en),        32'd0);
        chk({tag, "_ifid_en"}, 32'(o_ifid_en),      32'd1);
        chk({tag, "_flush"},   32'(o_ifid_flush),   32'd1);
        chk({tag, "_bubble"},  32'(o_idex_bubble),  32'd1);
        chk({tag, "_state"},   32'(o_state),        32'd0);
        chk({tag, "_stalls"},  32'(o_stall_count),  32'd0);
        chk({tag, "_timeout"}, 32'(o_imem_timeout), 32'd0);
    endtask

    task automatic set_idle();
        i_redirect    = 1'b0;
        i_imem_ready  = 1'b1;
        i_ex_mem_read = 1'b0;
        i_ex_rd       = 5'd0;
        i_id_rs1      = 5'd0;
        i_id_rs2      = 5'd0;
        i_id_uses_rs1 = 1'b0;
        i_id_uses_rs2 = 1'b0;
    endtask

    // One clock cycle: drive, check outputs against the model, clock, advance the model.
    task automatic cycle(input string tag, input bit redir, input bit rdy, input bit ld,
                         input logic [4:0] exrd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input bit u1, input bit u2);
        bit hazard;
        bit e_pc, e_en, e_fl, e_bub;
        i_redirect    = redir;
        i_imem_ready  = rdy;
        i_ex_mem_read = ld;
        i_ex_rd       = exrd;
        i_id_rs1      = rs1;
        i_id_rs2      = rs2;
        i_id_uses_rs1 = u1;
        i_id_uses_rs2 = u2;
        #1;
        hazard = ld && (exrd != 5'd0) && ((u1 && rs1 == exrd) || (u2 && rs2 == exrd));
        if (redir) begin
            {e_pc, e_en, e_fl, e_bub} = 4'b1111;
        end else if (hazard) begin
            {e_pc, e_en, e_fl, e_bub} = 4'b0001;
        end else begin
            e_pc  = rdy;
            e_en  = 1'b1;
            e_fl  = (m_mode == 2) || !rdy;
            e_bub = 1'b0;
        end
        chk({tag, "_pc_en"},   32'(o_pc_en),        32'(e_pc));
        chk({tag, "_ifid_en"}, 32'(o_ifid_en),      32'(e_en));
        chk({tag, "_flush"},   32'(o_ifid_flush),   32'(e_fl));
        chk({tag, "_bubble"},  32'(o_idex_bubble),  32'(e_bub));
        chk({tag, "_state"},   32'(o_state),        32'(m_mode));
        chk({tag, "_stalls"},  32'(o_stall_count),  32'(m_stall));
        chk({tag, "_timeout"}, 32'(o_imem_timeout), 32'(m_timeout));
        @(posedge i_clk);
        #1;
        if (!e_pc && m_stall < (2 ** CNT_W) - 1) m_stall++;
        if (redir) begin
            m_flush_left = FLUSH_CYCLES - 1;
            m_mode       = (FLUSH_CYCLES > 1) ? 2 : 0;
        end else if (!hazard) begin
            if (m_mode == 0 && !rdy) begin
                m_mode = 1;
                m_wait = 1;
            end else if (m_mode == 1) begin
                if (rdy) m_mode = 0;
                else if (m_wait < IMEM_TIMEOUT) m_wait++;
            end else if (m_mode == 2 && rdy) begin
                m_flush_left--;
                if (m_flush_left <= 0) m_mode = 0;
            end
            if (m_mode == 1 && m_wait >= IMEM_TIMEOUT) m_timeout = 1'b1;
        end
    endtask

    initial begin
        set_idle();
        model_reset();
        i_rst_n = 1'b0;
        #12;
        check_reset_values("reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Free-running fetch with no hazards
        for (int i = 0; i < 10; i++) cycle("run", 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);

        // Load-use via rs2, then the same pattern against x0
        cycle("luh_rs2", 0, 1, 1, 5'd5, 5'd1, 5'd5, 0, 1);
        cycle("after_luh", 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        cycle("luh_x0", 0, 1, 1, 5'd0, 5'd0, 5'd0, 1, 1);
        cycle("luh_rs1_unused", 0, 1, 1, 5'd7, 5'd7, 5'd2, 0, 1);

        // Redirect pulse and the trailing flush cycle
        cycle("redir", 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        cycle("redir_flush", 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        cycle("redir_run", 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);

        // Long fetch wait crosses the timeout; flag must survive the recovery
        for (int i = 0; i < 16; i++) cycle("imem_wait", 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("imem_back", 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);

        // Redirect together with a load-use hazard while waiting on fetch
        cycle("w5_enter", 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        cycle("w5_redir_luh", 1, 0, 1, 5'd3, 5'd3, 5'd0, 1, 0);
        cycle("w5_flush_wait", 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        cycle("w5_flush_rdy", 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        cycle("w5_run", 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);

        // Randomized traffic with small register indices to make hazards frequent
        for (int i = 0; i < 400; i++) begin
            cycle("rand",
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end

        // Reset asserted asynchronously in the middle of a flush
        cycle("pre_rst_redir", 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        chk("mid_flush_state", 32'(o_state), 32'd2);
        set_idle();
        #2;
        i_rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_reset();
        @(posedge i_clk);
        #1;
        for (int i = 0; i < 3; i++) cycle("post_rst", 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
